// File: rtl/pipe_hold_ctrl.sv
// Pipeline sequencing controller: merges jump, EX busy, load-use and bus holds
// into one hold_flag code, drives the PC redirect and keeps saturating debug counters.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_ex_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic             id_rs1_re_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs2_re_i,
  input  logic             hold_bus_i,
  input  logic             cnt_clr_i,
  output logic [2:0]       hold_flag_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;
  localparam logic [2:0] RELOAD    = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t     state, state_nxt;
  logic [2:0] flush_left, flush_left_nxt;
  logic       load_use;
  logic       jump_take;

  assign load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                    ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                     (id_rs2_re_i && (id_rs2_i == ex_rd_i)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
    end
  end

  always_comb begin
    hold_flag_o    = HOLD_NONE;
    jump_flag_o    = 1'b0;
    jump_addr_o    = '0;
    jump_take      = 1'b0;
    state_nxt      = state;
    flush_left_nxt = flush_left;
    if (jump_flag_i) begin
      // A jump wins in either state and restarts the flush window.
      hold_flag_o = HOLD_ID;
      jump_flag_o = 1'b1;
      jump_addr_o = jump_addr_i;
      jump_take   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt      = FLUSH;
        flush_left_nxt = RELOAD;
      end else begin
        state_nxt      = IDLE;
        flush_left_nxt = '0;
      end
    end else begin
      unique case (state)
        FLUSH: begin
          hold_flag_o = HOLD_ID;
          if (flush_left <= 3'd1) begin
            state_nxt      = IDLE;
            flush_left_nxt = '0;
          end else begin
            flush_left_nxt = flush_left - 3'd1;
          end
        end
        default: begin
          if (hold_ex_i || load_use) hold_flag_o = HOLD_ID;
          else if (hold_bus_i)       hold_flag_o = HOLD_PC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((hold_flag_o != HOLD_NONE) && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (jump_take && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: IDLE vector table, directed multi-cycle sequences,
// and randomized traffic against a flush-window reference model on two configurations.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag, hold_ex, ex_is_load, id_rs1_re, id_rs2_re, hold_bus, cnt_clr;
  logic [31:0] jump_addr;
  logic [4:0]  ex_rd, id_rs1, id_rs2;

  logic [2:0]  hold_a, hold_b;
  logic        jf_a, jf_b;
  logic [31:0] ja_a, ja_b;
  logic [3:0]  sc_a, fc_a;
  logic [5:0]  sc_b, fc_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_ex_i(hold_ex), .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd),
    .id_rs1_i(id_rs1), .id_rs1_re_i(id_rs1_re), .id_rs2_i(id_rs2), .id_rs2_re_i(id_rs2_re),
    .hold_bus_i(hold_bus), .cnt_clr_i(cnt_clr), .hold_flag_o(hold_a), .jump_flag_o(jf_a),
    .jump_addr_o(ja_a), .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
  );

  pipe_hold_ctrl #(.FLUSH_CYCLES(3), .CNT_W(6)) dut_b (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_ex_i(hold_ex), .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd),
    .id_rs1_i(id_rs1), .id_rs1_re_i(id_rs1_re), .id_rs2_i(id_rs2), .id_rs2_re_i(id_rs2_re),
    .hold_bus_i(hold_bus), .cnt_clr_i(cnt_clr), .hold_flag_o(hold_b), .jump_flag_o(jf_b),
    .jump_addr_o(ja_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
  );

  typedef struct {
    logic        jf;
    logic [31:0] ja;
    logic        hex;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        re1;
    logic [4:0]  rs2;
    logic        re2;
    logic        bus;
    logic [2:0]  e_hold;
    logic        e_jf;
    logic [31:0] e_ja;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    jump_flag = 1'b0; jump_addr = '0; hold_ex = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    id_rs1 = '0; id_rs1_re = 1'b0; id_rs2 = '0; id_rs2_re = 1'b0; hold_bus = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
  endtask

  task automatic chk_a(input string name, input logic [2:0] h, input logic j, input logic [31:0] a);
    chk({name, ".hold"}, 32'(hold_a), 32'(h));
    chk({name, ".jf"},   32'(jf_a),   32'(j));
    chk({name, ".addr"}, ja_a,        a);
  endtask

  // reference model state
  int          rem[2];
  int          msc[2];
  int          mfc[2];
  int          fcyc[2] = '{2, 3};
  int          cmax[2] = '{15, 63};
  logic [2:0]  mhold[2];

  initial begin
    vecs[0]  = '{0, 32'h0,        0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 3'd0, 0, 32'h0};
    vecs[1]  = '{1, 32'hDEAD_BEEF, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 3'd3, 1, 32'hDEAD_BEEF};
    vecs[2]  = '{0, 32'h1234,     1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 3'd3, 0, 32'h0};
    vecs[3]  = '{0, 32'h0,        0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 3'd3, 0, 32'h0};
    vecs[4]  = '{0, 32'h0,        0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 3'd0, 0, 32'h0};
    vecs[5]  = '{0, 32'h0,        0, 1, 5'd5, 5'd5, 0, 5'd5, 0, 0, 3'd0, 0, 32'h0};
    vecs[6]  = '{0, 32'h0,        0, 1, 5'd7, 5'd7, 1, 5'd2, 0, 0, 3'd3, 0, 32'h0};
    vecs[7]  = '{0, 32'h0,        0, 0, 5'd7, 5'd7, 1, 5'd7, 1, 0, 3'd0, 0, 32'h0};
    vecs[8]  = '{0, 32'h0,        0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 3'd1, 0, 32'h0};
    vecs[9]  = '{0, 32'h0,        1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 3'd3, 0, 32'h0};
    vecs[10] = '{1, 32'h0000_0040, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0, 1, 3'd3, 1, 32'h0000_0040};
    vecs[11] = '{0, 32'h0,        0, 1, 5'd9, 5'd8, 1, 5'd10, 1, 1, 3'd1, 0, 32'h0};

    do_reset();
    chk_a("reset", 3'd0, 1'b0, 32'h0);
    chk("reset.stall", 32'(sc_a), 32'd0);

    // IDLE combinational table: drive at negedge, inputs back to idle before the posedge
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      jump_flag = vecs[i].jf; jump_addr = vecs[i].ja; hold_ex = vecs[i].hex;
      ex_is_load = vecs[i].ld; ex_rd = vecs[i].rd; id_rs1 = vecs[i].rs1; id_rs1_re = vecs[i].re1;
      id_rs2 = vecs[i].rs2; id_rs2_re = vecs[i].re2; hold_bus = vecs[i].bus;
      #1;
      chk($sformatf("vec%0d", i), 32'(hold_a), 32'(vecs[i].e_hold));
      chk($sformatf("vec%0d.jf", i), 32'(jf_a), 32'(vecs[i].e_jf));
      chk($sformatf("vec%0d.addr", i), ja_a, vecs[i].e_ja);
      idle_inputs();
    end

    // single jump
    do_reset();
    jump_flag = 1'b1; jump_addr = 32'h0000_0100; #1;
    chk_a("jmp.N", 3'd3, 1'b1, 32'h100);
    tick(); idle_inputs(); #1;
    chk_a("jmp.N1", 3'd3, 1'b0, 32'h0);
    tick();
    chk_a("jmp.N2", 3'd0, 1'b0, 32'h0);
    chk("jmp.flush_cnt", 32'(fc_a), 32'd1);
    chk("jmp.stall_cnt", 32'(sc_a), 32'd2);

    // back-to-back jumps
    jump_flag = 1'b1; jump_addr = 32'h0000_0100; #1;
    chk_a("b2b.N", 3'd3, 1'b1, 32'h100);
    tick(); jump_addr = 32'h0000_0200; #1;
    chk_a("b2b.N1", 3'd3, 1'b1, 32'h200);
    tick(); idle_inputs(); #1;
    chk_a("b2b.N2", 3'd3, 1'b0, 32'h0);
    tick();
    chk_a("b2b.N3", 3'd0, 1'b0, 32'h0);
    chk("b2b.flush_cnt", 32'(fc_a), 32'd3);
    chk("b2b.stall_cnt", 32'(sc_a), 32'd5);

    // load-use for one cycle, then the load has moved on
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_re = 1'b1; #1;
    chk("lu.hit", 32'(hold_a), 32'd3);
    tick(); ex_is_load = 1'b0; #1;
    chk("lu.clear", 32'(hold_a), 32'd0);
    idle_inputs();

    // EX busy beats bus hold; bus alone freezes PC; jump beats EX busy
    hold_ex = 1'b1; hold_bus = 1'b1;
    for (int unsigned c = 0; c < 4; c++) begin
      #1; chk($sformatf("prio.ex%0d", c), 32'(hold_a), 32'd3);
      tick();
    end
    hold_ex = 1'b0; #1;
    chk("prio.bus", 32'(hold_a), 32'd1);
    tick(); hold_ex = 1'b1; jump_flag = 1'b1; jump_addr = 32'h0000_0300; #1;
    chk_a("prio.jmp", 3'd3, 1'b1, 32'h300);
    tick(); jump_flag = 1'b0; jump_addr = '0; #1;
    chk_a("prio.flush_ignores_ex", 3'd3, 1'b0, 32'h0);
    chk("prio.b_flush", 32'(hold_b), 32'd3);
    tick(); idle_inputs();

    // FLUSH_CYCLES=3 instance holds for three cycles
    do_reset();
    jump_flag = 1'b1; jump_addr = 32'h44; tick(); idle_inputs();
    #1; chk("fc3.c1", 32'(hold_b), 32'd3);
    tick(); chk("fc3.c2", 32'(hold_b), 32'd3);
    tick(); chk("fc3.c3", 32'(hold_b), 32'd0);

    // stall counter saturation and clear priority
    do_reset();
    hold_bus = 1'b1;
    for (int unsigned c = 0; c < 14; c++) tick();
    chk("sat.pre", 32'(sc_a), 32'd14);
    for (int unsigned c = 0; c < 3; c++) tick();
    chk("sat.hold", 32'(sc_a), 32'd15);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("sat.clr", 32'(sc_a), 32'd0);
    idle_inputs();

    // async reset mid-FLUSH
    do_reset();
    jump_flag = 1'b1; jump_addr = 32'h0000_0500; tick(); idle_inputs(); #1;
    chk("rst.pre", 32'(hold_a), 32'd3);
    rst = 1'b0; #1;
    chk_a("rst.async", 3'd0, 1'b0, 32'h0);
    chk("rst.b_hold", 32'(hold_b), 32'd0);
    chk("rst.stall", 32'(sc_a), 32'd0);
    chk("rst.flush", 32'(fc_a), 32'd0);
    @(negedge clk); rst = 1'b1;
    tick();
    chk("rst.after", 32'(hold_a), 32'd0);

    // randomized traffic vs model
    do_reset();
    for (int k = 0; k < 2; k++) begin rem[k] = 0; msc[k] = 0; mfc[k] = 0; end
    for (int unsigned cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      jump_flag  = ($urandom_range(0, 99) < 15);
      jump_addr  = $urandom;
      hold_ex    = ($urandom_range(0, 99) < 20);
      ex_is_load = $urandom_range(0, 1) == 1;
      ex_rd      = 5'($urandom_range(0, 3));
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_rs1_re  = $urandom_range(0, 1) == 1;
      id_rs2_re  = $urandom_range(0, 1) == 1;
      hold_bus   = ($urandom_range(0, 99) < 30);
      cnt_clr    = ($urandom_range(0, 99) < 4);
      #1;
      for (int k = 0; k < 2; k++) begin
        logic hazard;
        hazard = ex_is_load && ex_rd != 0 &&
                 ((id_rs1_re && id_rs1 == ex_rd) || (id_rs2_re && id_rs2 == ex_rd));
        if (jump_flag || rem[k] > 0 || hold_ex || hazard) mhold[k] = 3'd3;
        else if (hold_bus)                                 mhold[k] = 3'd1;
        else                                               mhold[k] = 3'd0;
      end
      chk("rnd.a.hold", 32'(hold_a), 32'(mhold[0]));
      chk("rnd.b.hold", 32'(hold_b), 32'(mhold[1]));
      chk("rnd.a.jf", 32'(jf_a), 32'(jump_flag));
      chk("rnd.b.addr", ja_b, jump_flag ? jump_addr : 32'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
        if (cnt_clr) begin
          msc[k] = 0; mfc[k] = 0;
        end else begin
          if (mhold[k] != 0 && msc[k] < cmax[k]) msc[k]++;
          if (jump_flag && mfc[k] < cmax[k])     mfc[k]++;
        end
        if (jump_flag)      rem[k] = fcyc[k] - 1;
        else if (rem[k] > 0) rem[k]--;
      end
      chk("rnd.a.stall", 32'(sc_a), 32'(msc[0]));
      chk("rnd.a.flush", 32'(fc_a), 32'(mfc[0]));
      chk("rnd.b.stall", 32'(sc_b), 32'(msc[1]));
      chk("rnd.b.flush", 32'(fc_b), 32'(mfc[1]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
